// File: rtl/ikascc_wave_reader.sv
// ikascc_wave_reader
// Per-channel waveform playback engine. A period down-counter reloads from
// the channel frequency register; each borrow advances the 5-bit wave RAM
// read address, and two enable cycles later the fetched byte becomes the
// channel's current signed sample.
//
// Ports:
//   i_EMUCLK       emulator clock, all state on rising edge
//   i_RST_n        asynchronous active-low reset
//   i_MCLK_PCEN_n  active-low clock enable; state moves only when 0
//   i_EN           channel enable
//   i_FREQ         period register value (step period = i_FREQ+1)
//   i_FREQ_WR      strobe: period register written, counter reloads
//   i_RESET_PHASE  strobe: restart waveform at address 0
//   o_RAM_ADDR     registered wave RAM read address
//   i_RAM_DATA     wave RAM read data, one enable cycle latency
//   o_SAMPLE       current sample (two's complement)
//   o_SAMPLE_VLD   one-enable-cycle pulse when o_SAMPLE updates
//   o_STEP         one-enable-cycle pulse on each address advance
module ikascc_wave_reader #(
  parameter int FW   = 12,
  parameter int AW   = 5,
  parameter int DW   = 8,
  parameter int MINF = 9
) (
  input  logic          i_EMUCLK,
  input  logic          i_RST_n,
  input  logic          i_MCLK_PCEN_n,
  input  logic          i_EN,
  input  logic [FW-1:0] i_FREQ,
  input  logic          i_FREQ_WR,
  input  logic          i_RESET_PHASE,
  output logic [AW-1:0] o_RAM_ADDR,
  input  logic [DW-1:0] i_RAM_DATA,
  output logic [DW-1:0] o_SAMPLE,
  output logic          o_SAMPLE_VLD,
  output logic          o_STEP
);

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_COUNT = 2'd1,
    ST_FETCH = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  localparam logic [FW-1:0] MINF_V   = FW'(MINF);
  localparam logic [FW-1:0] CNT_ONE  = {{(FW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

  state_t        state_r;
  logic [FW-1:0] cnt_r;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] sample_r;
  logic          vld_r;
  logic          step_r;

  logic          run_s;
  logic          borrow_s;

  // Run conditions and borrow detection
  always_comb begin
    run_s    = i_EN && (i_FREQ >= MINF_V);
    borrow_s = (cnt_r == {FW{1'b0}});
  end

  // Playback state machine, period counter and registered outputs
  always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state_r  <= ST_HALT;
      cnt_r    <= {FW{1'b0}};
      addr_r   <= {AW{1'b0}};
      sample_r <= {DW{1'b0}};
      vld_r    <= 1'b0;
      step_r   <= 1'b0;
    end else if (!i_MCLK_PCEN_n) begin
      step_r <= 1'b0;
      vld_r  <= 1'b0;
      if ((state_r == ST_HALT) || !run_s) begin
        // Halted (or aborting a fetch): counter holds, no sample pulse.
        if (i_RESET_PHASE) begin
          addr_r <= {AW{1'b0}};
        end
        if (!i_EN) begin
          sample_r <= {DW{1'b0}};
        end
        if (run_s) begin
          state_r <= ST_COUNT;
          cnt_r   <= i_FREQ;
        end else begin
          state_r <= ST_HALT;
        end
      end else if (i_RESET_PHASE) begin
        // Phase restart beats borrow and period write; address 0 is re-fetched.
        addr_r  <= {AW{1'b0}};
        cnt_r   <= i_FREQ;
        state_r <= ST_FETCH;
      end else begin
        if (i_FREQ_WR || borrow_s) begin
          cnt_r <= i_FREQ;
        end else begin
          cnt_r <= cnt_r - CNT_ONE;
        end
        case (state_r)
          ST_COUNT: begin
            // A period write on the borrow cycle swallows the step.
            if (borrow_s && !i_FREQ_WR) begin
              addr_r  <= addr_r + ADDR_ONE;
              step_r  <= 1'b1;
              state_r <= ST_FETCH;
            end
          end
          ST_FETCH: begin
            state_r <= ST_LATCH;
          end
          ST_LATCH: begin
            sample_r <= i_RAM_DATA;
            vld_r    <= 1'b1;
            state_r  <= ST_COUNT;
          end
          default: begin
            state_r <= ST_HALT;
          end
        endcase
      end
    end
  end

  assign o_RAM_ADDR   = addr_r;
  assign o_SAMPLE     = sample_r;
  assign o_SAMPLE_VLD = vld_r;
  assign o_STEP       = step_r;

endmodule

// File: tb/tb_ikascc_wave_reader.sv
module tb_ikascc_wave_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pcen_n;
  logic        en;
  logic [11:0] freq;
  logic        freq_wr;
  logic        reset_phase;
  logic [4:0]  ram_addr;
  logic [7:0]  ram_data;
  logic [7:0]  sample;
  logic        sample_vld;
  logic        step;

  ikascc_wave_reader dut (
    .i_EMUCLK      (clk),
    .i_RST_n       (rst_n),
    .i_MCLK_PCEN_n (pcen_n),
    .i_EN          (en),
    .i_FREQ        (freq),
    .i_FREQ_WR     (freq_wr),
    .i_RESET_PHASE (reset_phase),
    .o_RAM_ADDR    (ram_addr),
    .i_RAM_DATA    (ram_data),
    .o_SAMPLE      (sample),
    .o_SAMPLE_VLD  (sample_vld),
    .o_STEP        (step)
  );

  always #5 clk = ~clk;

  // Wave RAM: RAM[k] = 5k, one enable cycle read latency
  logic [7:0] ram [32];
  initial for (int k = 0; k < 32; k++) ram[k] = 8'(k * 5);
  always @(posedge clk) if (!pcen_n) ram_data <= ram[ram_addr];

  typedef struct { int cyc; int val; } ev_t;
  ev_t step_q[$];
  ev_t vld_q[$];

  int checks = 0;
  int failures = 0;
  int ecyc = 0;
  logic en_edge = 1'b0;
  int gate = 1;
  int phase = 0;
  logic was_en;
  int clk_n = 0;
  int step_run = 0;
  logic step_prev = 1'b0;
  int last_rise = 0;
  int prev_rise = 0;

  // Enable-cycle counter (counts only out-of-reset enable edges)
  always @(posedge clk) begin
    if (rst_n && !pcen_n) begin
      ecyc    <= ecyc + 1;
      en_edge <= 1'b1;
    end else begin
      en_edge <= 1'b0;
    end
  end

  // Monitor: pop expected pulses and compare on each enable edge
  always @(negedge clk) begin
    ev_t e;
    clk_n++;
    if (en_edge && step) begin
      checks++;
      if (step_q.size() == 0) begin
        failures++;
        $display("FAIL step_unexpected: cycle %0d addr %0d, required no step", ecyc, ram_addr);
      end else begin
        e = step_q.pop_front();
        if (e.cyc != ecyc || e.val != int'(ram_addr)) begin
          failures++;
          $display("FAIL step: cycle %0d addr %0d, required cycle %0d addr %0d", ecyc, ram_addr, e.cyc, e.val);
        end
      end
    end
    if (en_edge && sample_vld) begin
      checks++;
      if (vld_q.size() == 0) begin
        failures++;
        $display("FAIL vld_unexpected: cycle %0d sample %0d, required no vld", ecyc, sample);
      end else begin
        e = vld_q.pop_front();
        if (e.cyc != ecyc || e.val != int'(sample)) begin
          failures++;
          $display("FAIL vld: cycle %0d sample %0d, required cycle %0d sample %0d", ecyc, sample, e.cyc, e.val);
        end
      end
    end
    // o_STEP width in EMUCLK cycles must equal one enable period
    if (step) begin
      if (!step_prev) begin
        prev_rise = last_rise;
        last_rise = clk_n;
      end
      step_run++;
    end else if (step_prev) begin
      checks++;
      if (step_run != gate) begin
        failures++;
        $display("FAIL step_width: %0d clocks, required %0d", step_run, gate);
      end
      step_run = 0;
    end
    step_prev = step;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    was_en = !pcen_n;
    #1;
    phase++;
    pcen_n = ((phase % gate) != 0);
  endtask

  task automatic etick();
    do tick(); while (!was_en);
  endtask

  task automatic wait_until(input int target);
    while (ecyc < target) etick();
  endtask

  task automatic push_step(input int c, input int a);
    ev_t e;
    e.cyc = c; e.val = a;
    step_q.push_back(e);
  endtask

  task automatic push_vld(input int c, input int s);
    ev_t e;
    e.cyc = c; e.val = s;
    vld_q.push_back(e);
  endtask

  int c0, c1, c2;

  initial begin
    rst_n = 1'b0; pcen_n = 1'b0; en = 1'b0; freq = 12'd0;
    freq_wr = 1'b0; reset_phase = 1'b0;
    repeat (3) tick();
    chk("reset_addr", int'(ram_addr), 0);
    chk("reset_sample", int'(sample), 0);
    chk("reset_vld", int'(sample_vld), 0);
    chk("reset_step", int'(step), 0);

    // Short run, then async reset mid-operation
    tick();
    rst_n = 1'b1; en = 1'b1; freq = 12'd9;
    c0 = ecyc + 1;
    push_step(c0 + 10, 1); push_vld(c0 + 12, 5);
    push_step(c0 + 20, 2); push_vld(c0 + 22, 10);
    wait_until(c0 + 25);
    chk("pre_reset_addr", int'(ram_addr), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_addr", int'(ram_addr), 0);
    chk("async_sample", int'(sample), 0);
    chk("async_vld", int'(sample_vld), 0);
    chk("async_step", int'(step), 0);
    repeat (3) tick();
    tick();
    rst_n = 1'b1;

    // Steady playback through the 31 -> 0 wrap
    c0 = ecyc + 1;
    for (int k = 1; k <= 33; k++) begin
      push_step(c0 + 10 * k, k % 32);
      push_vld(c0 + 10 * k + 2, (5 * (k % 32)) % 256);
    end
    wait_until(c0 + 332);
    chk("wrap_addr", int'(ram_addr), 1);
    chk("wrap_sample", int'(sample), 5);

    // Halt threshold: period 8 never steps, sample held
    freq = 12'd8;
    wait_until(ecyc + 100);
    chk("halt_addr", int'(ram_addr), 1);
    chk("halt_sample", int'(sample), 5);

    // Resume with period 9, then drop enable while in FETCH
    freq = 12'd9;
    c1 = ecyc;
    push_step(c1 + 11, 2);
    wait_until(c1 + 11);
    en = 1'b0;
    wait_until(c1 + 12);
    chk("abort_sample", int'(sample), 0);
    chk("abort_vld", int'(sample_vld), 0);
    wait_until(ecyc + 20);
    chk("abort_addr", int'(ram_addr), 2);

    // Period write coinciding with a borrow
    en = 1'b1;
    c2 = ecyc;
    push_step(c2 + 11, 3); push_vld(c2 + 13, 15);
    wait_until(c2 + 20);
    freq = 12'd20; freq_wr = 1'b1;
    etick();
    freq_wr = 1'b0;
    chk("wr_no_step", int'(step), 0);
    chk("wr_addr", int'(ram_addr), 3);
    push_step(c2 + 42, 4); push_vld(c2 + 44, 20);

    // Phase reset together with borrow and period write
    wait_until(c2 + 62);
    reset_phase = 1'b1; freq_wr = 1'b1;
    etick();
    reset_phase = 1'b0; freq_wr = 1'b0;
    chk("rp_addr", int'(ram_addr), 0);
    chk("rp_no_step", int'(step), 0);
    push_vld(c2 + 65, 0);
    push_step(c2 + 84, 1); push_vld(c2 + 86, 5);
    wait_until(c2 + 86);

    // Clock-enable gating: one enable per 4 EMUCLK, period 9
    freq = 12'd9;
    gate = 4;
    for (int k = 0; k < 4; k++) begin
      push_step(c2 + 105 + 10 * k, 2 + k);
      push_vld(c2 + 107 + 10 * k, 5 * (2 + k));
    end
    wait_until(c2 + 137);
    chk("gated_spacing", last_rise - prev_rise, 40);
    repeat (8) tick();

    chk("step_q_drained", step_q.size(), 0);
    chk("vld_q_drained", vld_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
